// File: rtl/adder_pipe_arb.sv
// adder_pipe_arb: shares one fixed-latency 16-operand adder pipe between two
// requesters. A round-robin arbiter issues one operand vector per cycle. A tag
// pipeline matched to the adder latency steers each sum into a per-requester
// first-word-fall-through response FIFO. Admission is credit based, so a
// returning sum always finds FIFO space.
// Optional build macro ADDER_PIPE_ARB_STRICT_PRIO_EN: requester 0 gets fixed
// priority instead of round-robin.
module adder_pipe_arb #(
   parameter int unsigned LAT        = 5,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [63:0] req0_data_i,
   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [63:0] req1_data_i,
   output logic [63:0] pipe_ops_o,
   input  logic [7:0]  pipe_sum_i,
   output logic        rsp0_valid_o,
   input  logic        rsp0_ready_i,
   output logic [7:0]  rsp0_sum_o,
   output logic        rsp1_valid_o,
   input  logic        rsp1_ready_i,
   output logic [7:0]  rsp1_sum_o,
   output logic        busy_o
);

   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam int unsigned CW      = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   logic [1:0]    req_valid;
   logic [1:0]    rsp_ready;
   logic [1:0]    eligible;
   logic [1:0]    grant;
   logic [1:0]    push;
   logic [1:0]    pop;
   logic [CW-1:0] fifo_count [2];
   logic [CW-1:0] inflight   [2];
   logic [AW-1:0] wr_ptr     [2];
   logic [AW-1:0] rd_ptr     [2];
   logic [7:0]    fifo_mem   [2][FIFO_DEPTH];
   logic [7:0]    head       [2];
   logic [LAT:0]  tag_valid;
   logic [LAT:0]  tag_id;

   assign req_valid = {req1_valid_i, req0_valid_i};
   assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};

   // A requester may issue only while buffered plus outstanding results leave FIFO room
   always_comb begin
      eligible = '0;
      for (int unsigned r = 0; r < 2; r++) begin
         eligible[r] = rst_n && req_valid[r] &&
                       (({1'b0, fifo_count[r]} + {1'b0, inflight[r]}) < DEPTH_C);
      end
   end

`ifdef ADDER_PIPE_ARB_STRICT_PRIO_EN
   // Fixed priority: requester 0 wins whenever it is eligible
   always_comb begin
      grant    = '0;
      grant[0] = eligible[0];
      grant[1] = eligible[1] && !eligible[0];
   end
`else
   logic last_grant;

   // Round-robin: on contention the requester not granted last time wins
   always_comb begin
      grant = '0;
      if (eligible[0] && eligible[1]) begin
         grant[0] = last_grant;
         grant[1] = !last_grant;
      end else begin
         grant = eligible;
      end
   end

   // Remember the most recent winner; reset favours requester 0 first
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (grant != 2'b00) begin
         last_grant <= grant[1];
      end
   end
`endif

   assign req0_ready_o = grant[0];
   assign req1_ready_o = grant[1];

   // Register the granted operands and launch a tag alongside them
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe_ops_o <= '0;
         tag_valid  <= '0;
         tag_id     <= '0;
      end else begin
         if (grant[1]) begin
            pipe_ops_o <= req1_data_i;
         end else if (grant[0]) begin
            pipe_ops_o <= req0_data_i;
         end else begin
            pipe_ops_o <= '0;
         end
         tag_valid <= {tag_valid[LAT-1:0], |grant};
         tag_id    <= {tag_id[LAT-1:0], grant[1]};
      end
   end

   assign push[0] = tag_valid[LAT] && !tag_id[LAT];
   assign push[1] = tag_valid[LAT] &&  tag_id[LAT];
   assign pop[0]  = (fifo_count[0] != '0) && rsp_ready[0];
   assign pop[1]  = (fifo_count[1] != '0) && rsp_ready[1];

   // Per-requester in-flight counters, FIFO occupancy and pointers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < 2; r++) begin
            fifo_count[r] <= '0;
            inflight[r]   <= '0;
            wr_ptr[r]     <= '0;
            rd_ptr[r]     <= '0;
         end
      end else begin
         for (int unsigned r = 0; r < 2; r++) begin
            case ({grant[r], push[r]})
               2'b10:   inflight[r] <= inflight[r] + CW'(1);
               2'b01:   inflight[r] <= inflight[r] - CW'(1);
               default: inflight[r] <= inflight[r];
            endcase
            case ({push[r], pop[r]})
               2'b10:   fifo_count[r] <= fifo_count[r] + CW'(1);
               2'b01:   fifo_count[r] <= fifo_count[r] - CW'(1);
               default: fifo_count[r] <= fifo_count[r];
            endcase
            if (push[r]) begin
               wr_ptr[r] <= wr_ptr[r] + AW'(1);
            end
            if (pop[r]) begin
               rd_ptr[r] <= rd_ptr[r] + AW'(1);
            end
         end
      end
   end

   // FIFO storage; contents need no reset because the counts gate visibility
   always_ff @(posedge clk) begin
      for (int unsigned r = 0; r < 2; r++) begin
         if (push[r]) begin
            fifo_mem[r][wr_ptr[r]] <= pipe_sum_i;
         end
      end
   end

   assign head[0] = fifo_mem[0][rd_ptr[0]];
   assign head[1] = fifo_mem[1][rd_ptr[1]];

   assign rsp0_valid_o = (fifo_count[0] != '0);
   assign rsp1_valid_o = (fifo_count[1] != '0);
   assign rsp0_sum_o   = rsp0_valid_o ? head[0] : '0;
   assign rsp1_sum_o   = rsp1_valid_o ? head[1] : '0;

   assign busy_o = (|inflight[0]) | (|inflight[1]) | (|fifo_count[0]) | (|fifo_count[1]);

endmodule

// File: tb/tb_adder_pipe_arb.sv
// Bench for adder_pipe_arb: models the external adder pipe, keeps a
// queue-based scoreboard of expected results per requester and runs directed
// scenarios with hand-computed expectations.
module tb_adder_pipe_arb;

   localparam int LAT   = 5;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid_i, req1_valid_i;
   logic        req0_ready_o, req1_ready_o;
   logic [63:0] req0_data_i, req1_data_i;
   logic [63:0] pipe_ops_o;
   logic [7:0]  pipe_sum_i;
   logic        rsp0_valid_o, rsp1_valid_o;
   logic        rsp0_ready_i, rsp1_ready_i;
   logic [7:0]  rsp0_sum_o, rsp1_sum_o;
   logic        busy_o;

   always #5 clk = ~clk;

   adder_pipe_arb #(.LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0_valid_i (req0_valid_i),
      .req0_ready_o (req0_ready_o),
      .req0_data_i  (req0_data_i),
      .req1_valid_i (req1_valid_i),
      .req1_ready_o (req1_ready_o),
      .req1_data_i  (req1_data_i),
      .pipe_ops_o   (pipe_ops_o),
      .pipe_sum_i   (pipe_sum_i),
      .rsp0_valid_o (rsp0_valid_o),
      .rsp0_ready_i (rsp0_ready_i),
      .rsp0_sum_o   (rsp0_sum_o),
      .rsp1_valid_o (rsp1_valid_o),
      .rsp1_ready_i (rsp1_ready_i),
      .rsp1_sum_o   (rsp1_sum_o),
      .busy_o       (busy_o)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   function automatic logic [7:0] nsum(input logic [63:0] d);
      logic [7:0] s;
      s = 8'd0;
      for (int k = 0; k < 16; k++) s = s + {4'd0, d[4*k +: 4]};
      return s;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // External adder pipe: LAT registered stages
   logic [7:0] stage [LAT];
   always @(posedge clk) begin
      stage[0] <= nsum(pipe_ops_o);
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
   end
   assign pipe_sum_i = stage[LAT-1];

   // Scoreboard: each accepted vector becomes an entry due LAT+1 edges later
   typedef struct { logic [7:0] sum; int due; } ent_t;
   ent_t q0[$];
   ent_t q1[$];
   logic        m_last = 1'b1;
   logic        chk_en = 1'b0;
   logic [63:0] exp_ops = '0;
   logic        e0, e1, g0, g1, v0, v1;
   logic [7:0]  log0[$];

   always @(negedge clk) begin
      if (chk_en) begin
         e0 = req0_valid_i && rst_n && (q0.size() < DEPTH);
         e1 = req1_valid_i && rst_n && (q1.size() < DEPTH);
`ifdef ADDER_PIPE_ARB_STRICT_PRIO_EN
         g0 = e0;
         g1 = e1 && !e0;
`else
         if (e0 && e1) begin
            g0 = m_last;
            g1 = !m_last;
         end else begin
            g0 = e0;
            g1 = e1;
         end
`endif
         v0 = (q0.size() > 0) && (q0[0].due <= cyc);
         v1 = (q1.size() > 0) && (q1[0].due <= cyc);
         chk("req0_ready", 64'(req0_ready_o), 64'(g0));
         chk("req1_ready", 64'(req1_ready_o), 64'(g1));
         chk("rsp0_valid", 64'(rsp0_valid_o), 64'(v0));
         chk("rsp1_valid", 64'(rsp1_valid_o), 64'(v1));
         chk("busy", 64'(busy_o), 64'((q0.size() + q1.size()) > 0));
         chk("pipe_ops", pipe_ops_o, exp_ops);
         if (v0) chk("rsp0_sum", 64'(rsp0_sum_o), 64'(q0[0].sum));
         if (v1) chk("rsp1_sum", 64'(rsp1_sum_o), 64'(q1[0].sum));
         if (rst_n) begin
            exp_ops = '0;
            if (g0) begin
               q0.push_back('{sum: nsum(req0_data_i), due: cyc + LAT + 2});
               m_last  = 1'b0;
               exp_ops = req0_data_i;
            end
            if (g1) begin
               q1.push_back('{sum: nsum(req1_data_i), due: cyc + LAT + 2});
               m_last  = 1'b1;
               exp_ops = req1_data_i;
            end
            if (v0 && rsp0_ready_i) void'(q0.pop_front());
            if (v1 && rsp1_ready_i) void'(q1.pop_front());
         end
      end
      if (!rst_n) begin
         q0.delete();
         q1.delete();
         m_last  = 1'b1;
         exp_ops = '0;
         chk_en  = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rsp0_valid_o && rsp0_ready_i) log0.push_back(rsp0_sum_o);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp0(output int t, output logic [7:0] s);
      t = -1;
      s = 8'd0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rsp0_valid_o) begin
            t = cyc;
            s = rsp0_sum_o;
            break;
         end
      end
      if (t < 0) chk("rsp0_timeout", 64'd0, 64'd1);
   endtask

   task automatic single_req0(input string name, input logic [63:0] d, input int exp_sum);
      int acc, t;
      logic [7:0] s;
      req0_valid_i = 1'b1;
      req0_data_i  = d;
      tick();
      acc = cyc;
      req0_valid_i = 1'b0;
      wait_rsp0(t, s);
      chk({name, "_latency"}, 64'(t - acc), 64'd6);
      chk({name, "_sum"}, 64'(s), 64'(exp_sum));
      chk({name, "_rsp1_idle"}, 64'(rsp1_valid_o), 64'd0);
      @(negedge clk);
      chk({name, "_busy_after_pop"}, 64'(busy_o), 64'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0, n1, base, nr;
      int accs[9];
      logic ok, prev0;
      logic [3:0] nib;

      rst_n = 1'b0;
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      req0_data_i = '0;    req1_data_i = '0;
      rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: single full-scale vector
      single_req0("t1", 64'hFFFF_FFFF_FFFF_FFFF, 240);

      // 2: both requesters continuously valid
      req0_valid_i = 1'b1; req0_data_i = 64'hFEDC_BA98_7654_3210;
      req1_valid_i = 1'b1; req1_data_i = 64'h1111_1111_1111_1111;
      prev0 = 1'b0; nr = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
`ifndef ADDER_PIPE_ARB_STRICT_PRIO_EN
         chk("t2_one_grant", 64'(req0_ready_o ^ req1_ready_o), 64'd1);
         if (i > 0) chk("t2_alternate", 64'(req0_ready_o), 64'(!prev0));
         prev0 = req0_ready_o;
         if (i >= 12) nr += int'(rsp0_valid_o);
`endif
         if (rsp0_valid_o) chk("t2_rsp0_sum", 64'(rsp0_sum_o), 64'd120);
         if (rsp1_valid_o) chk("t2_rsp1_sum", 64'(rsp1_sum_o), 64'd16);
      end
`ifndef ADDER_PIPE_ARB_STRICT_PRIO_EN
      chk("t2_rsp0_rate", 64'(nr), 64'd6);
`endif
      tick();
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      repeat (15) tick();

      // 3: req0 back-to-back distinct vectors
      base = log0.size();
      for (int v = 1; v <= 8; v++) begin
         nib = v[3:0];
         req0_valid_i = 1'b1;
         req0_data_i  = {16{nib}};
         ok = 1'b0;
         for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (req0_ready_o) ok = 1'b1;
            tick();
            if (ok) break;
         end
         if (!ok) chk("t3_accept_timeout", 64'd0, 64'd1);
         accs[v] = cyc;
      end
      req0_valid_i = 1'b0;
      for (int k = 2; k <= 4; k++) chk("t3_back_to_back", 64'(accs[k] - accs[1]), 64'(k - 1));
      repeat (20) tick();
      chk("t3_count", 64'(log0.size() - base), 64'd8);
      for (int v = 1; v <= 8; v++) begin
         if (log0.size() >= base + v) chk("t3_order", 64'(log0[base + v - 1]), 64'(16 * v));
      end

      // 4: rsp0 back-pressure exhausts req0 credit, req1 still served
      rsp0_ready_i = 1'b0;
      req0_valid_i = 1'b1; req0_data_i = {16{4'h3}};
      req1_valid_i = 1'b1; req1_data_i = {16{4'h1}};
      n0 = 0; n1 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n0 += int'(req0_ready_o);
         n1 += int'(req1_ready_o);
         tick();
      end
      chk("t4_req0_accepts", 64'(n0), 64'd4);
      chk("t4_req1_served", 64'(n1 > 0), 64'd1);
      @(negedge clk);
      chk("t4_req0_blocked", 64'(req0_ready_o), 64'd0);
      tick();
      rsp0_ready_i = 1'b1;
      n0 = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n0 += int'(req0_ready_o);
         tick();
         if (i == 0) rsp0_ready_i = 1'b0;
      end
      chk("t4_one_more", 64'(n0), 64'd1);
      rsp0_ready_i = 1'b1;
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      repeat (20) tick();

      // 5: reset while results are in flight
      req0_valid_i = 1'b1; req0_data_i = {16{4'h5}};
      n0 = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (req0_ready_o) n0++;
         tick();
         if (n0 == 3) break;
      end
      req0_valid_i = 1'b0;
      chk("t5_accepts", 64'(n0), 64'd3);
      tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      nr = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         nr += int'(rsp0_valid_o | rsp1_valid_o);
      end
      chk("t5_no_rsp", 64'(nr), 64'd0);
      chk("t5_idle", 64'(busy_o), 64'd0);
      tick();
      single_req0("t5_new", {16{4'h2}}, 32);

`ifdef ADDER_PIPE_ARB_STRICT_PRIO_EN
      // 6: fixed priority until req0 credit runs out
      rsp0_ready_i = 1'b0;
      req0_valid_i = 1'b1; req0_data_i = {16{4'h4}};
      req1_valid_i = 1'b1; req1_data_i = {16{4'h6}};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t6_req0_prio", 64'(req0_ready_o), 64'(i < 4));
         chk("t6_req1_after", 64'(req1_ready_o), 64'(i >= 4));
         tick();
      end
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      rsp0_ready_i = 1'b1;
      repeat (20) tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
